// File: rtl/force_override_bank.sv
// force_override_bank: per-channel register bank with force/release/timed-force overrides.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   wr_en, wr_ch, wr_data       normal write into a channel's stored register
//   cmd_valid/cmd_ready         override command handshake (one command per two cycles)
//   cmd_op, cmd_ch, cmd_data,   opcode (00 NOP, 01 FORCE, 10 RELEASE, 11 TIMED_FORCE),
//   cmd_hold                    target channel, force value, timed-force duration
//   q                           effective values, channel n at [n*WIDTH +: WIDTH]
//   forced                      per-channel override-active flags
//   expired                     one-cycle pulse on timed auto-release
//   cmd_err                     one-cycle pulse for an accepted command with cmd_ch >= CHANNELS
module force_override_bank #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int HOLD_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(CHANNELS)-1:0]   wr_ch,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [3:0]                    cmd_ch,
    input  logic [WIDTH-1:0]              cmd_data,
    input  logic [HOLD_W-1:0]             cmd_hold,
    output logic [CHANNELS*WIDTH-1:0]     q,
    output logic [CHANNELS-1:0]           forced,
    output logic [CHANNELS-1:0]           expired,
    output logic                          cmd_err
);
    localparam int CW = $clog2(CHANNELS);

    logic acc, ch_ok;

    assign acc   = cmd_valid & cmd_ready;
    assign ch_ok = {1'b0, cmd_ch} < 5'(CHANNELS);

    // Ready drops for the cycle after every acceptance, then returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            cmd_ready <= !acc;
            cmd_err   <= acc && !ch_ok;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [WIDTH-1:0]  st, fv, qr, st_n, fv_n;
        logic [HOLD_W-1:0] cnt, cnt_n;
        logic              fo, tm, ex, fo_n, tm_n, ex_n;
        logic              sel, wr, set, rel;

        always_comb begin
            sel   = acc && ch_ok && cmd_ch == 4'(c) && cmd_op != 2'b00;
            wr    = wr_en && wr_ch == CW'(c);
            set   = sel && cmd_op[0];
            // A command on this channel takes precedence over the timer running out.
            ex_n  = tm && cnt == HOLD_W'(1) && !sel;
            rel   = (sel && cmd_op == 2'b10 && fo) || ex_n;
            fo_n  = set ? 1'b1 : rel ? 1'b0 : fo;
            tm_n  = set ? cmd_op[1] : rel ? 1'b0 : tm;
            cnt_n = set ? (cmd_op[1] ? (cmd_hold == '0 ? HOLD_W'(1) : cmd_hold) : '0)
                  : rel ? '0 : tm ? cnt - HOLD_W'(1) : cnt;
            fv_n  = set ? cmd_data : fv;
            // On release the stored value inherits the force value unless a write lands on the same edge.
            st_n  = set ? st : (wr && (rel || !fo)) ? wr_data : rel ? fv : st;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st  <= '0;
                fv  <= '0;
                qr  <= '0;
                cnt <= '0;
                fo  <= 1'b0;
                tm  <= 1'b0;
                ex  <= 1'b0;
            end else begin
                st  <= st_n;
                fv  <= fv_n;
                qr  <= fo_n ? fv_n : st_n;
                cnt <= cnt_n;
                fo  <= fo_n;
                tm  <= tm_n;
                ex  <= ex_n;
            end
        end

        assign q[c*WIDTH +: WIDTH] = qr;
        assign forced[c]           = fo;
        assign expired[c]          = ex;
    end
endmodule

// File: tb/tb_force_override_bank.sv
// tb_force_override_bank: randomized and directed checks of force_override_bank against a behavioural model.
module tb_force_override_bank;
    localparam int W = 4;
    localparam int N = 4;
    localparam int H = 8;

    logic           clk = 0;
    logic           rst_n = 0;
    logic           wr_en = 0;
    logic [1:0]     wr_ch = 0;
    logic [W-1:0]   wr_data = 0;
    logic           cmd_valid = 0;
    logic           cmd_ready;
    logic [1:0]     cmd_op = 0;
    logic [3:0]     cmd_ch = 0;
    logic [W-1:0]   cmd_data = 0;
    logic [H-1:0]   cmd_hold = 0;
    logic [N*W-1:0] q;
    logic [N-1:0]   forced, expired;
    logic           cmd_err;

    force_override_bank #(.WIDTH(W), .CHANNELS(N), .HOLD_W(H)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_ch(cmd_ch), .cmd_data(cmd_data), .cmd_hold(cmd_hold),
        .q(q), .forced(forced), .expired(expired), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: stored value, force value, override flag, forced cycles still to run (0 = untimed).
    logic [W-1:0]   m_st[N], m_fv[N];
    bit             m_fo[N], m_exp[N];
    int             m_rem[N];
    bit             m_rdy, m_err;
    logic [N*W-1:0] eq;
    logic [N-1:0]   ef, ee;

    task automatic build;
        for (int c = 0; c < N; c++) begin
            eq[c*W +: W] = m_fo[c] ? m_fv[c] : m_st[c];
            ef[c] = m_fo[c];
            ee[c] = m_exp[c];
        end
    endtask

    task automatic model_reset;
        for (int c = 0; c < N; c++) begin
            m_st[c] = 0; m_fv[c] = 0; m_fo[c] = 0; m_exp[c] = 0; m_rem[c] = 0;
        end
        m_rdy = 0; m_err = 0;
        build();
    endtask

    // Advance the model with the inputs now driven, then let the DUT take the same edge.
    task automatic tick;
        bit acc;
        int h;
        acc = cmd_valid && m_rdy;
        for (int c = 0; c < N; c++) begin
            bit hit, w;
            hit = acc && cmd_ch == c && cmd_op != 2'b00;
            w = wr_en && wr_ch == c;
            m_exp[c] = 0;
            if (hit && (cmd_op == 2'b01 || cmd_op == 2'b11)) begin
                m_fv[c] = cmd_data;
                m_fo[c] = 1;
                h = int'(cmd_hold);
                m_rem[c] = cmd_op == 2'b11 ? (h < 1 ? 1 : h) : 0;
            end else if ((hit && cmd_op == 2'b10 && m_fo[c]) || m_rem[c] == 1) begin
                m_exp[c] = !hit;
                m_fo[c] = 0;
                m_rem[c] = 0;
                m_st[c] = w ? wr_data : m_fv[c];
            end else begin
                if (m_rem[c] > 0) m_rem[c]--;
                if (w && !m_fo[c]) m_st[c] = wr_data;
            end
        end
        m_err = acc && cmd_ch >= N;
        m_rdy = !acc;
        build();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] op, input logic [3:0] ch, input logic [W-1:0] d, input logic [H-1:0] hd);
        cmd_valid = 1; cmd_op = op; cmd_ch = ch; cmd_data = d; cmd_hold = hd;
        tick();
        cmd_valid = 0;
        tick();
    endtask

    task automatic wr(input logic [1:0] ch, input logic [W-1:0] d);
        wr_en = 1; wr_ch = ch; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        model_reset();
        #1;
        tests++;
        if (q !== '0 || forced !== '0 || expired !== '0 || cmd_err !== 0 || cmd_ready !== 0) begin
            fails++;
            $display("FAIL reset_state q=%h forced=%b expired=%b err=%b ready=%b, required all 0", q, forced, expired, cmd_err, cmd_ready);
        end
        @(posedge clk); #2;
        rst_n = 1;
        tests++;
        if (cmd_ready !== 0) begin
            fails++;
            $display("FAIL ready_before_edge got %b need 0", cmd_ready);
        end
        tick();
        tests++;
        if (cmd_ready !== 1) begin
            fails++;
            $display("FAIL ready_after_reset got %b need 1", cmd_ready);
        end
    endtask

    task automatic test_force_release;
        wr(1, 4'h3);
        tests++;
        if (q[1*W +: W] !== 4'h3) begin fails++; $display("FAIL write_ch1 got %h need 3", q[1*W +: W]); end
        cmd(2'b01, 1, 4'h1, 0);
        wr(1, 4'h7);
        tests++;
        if (q[1*W +: W] !== 4'h1 || forced[1] !== 1) begin
            fails++;
            $display("FAIL force_blocks_write q=%h forced=%b need 1/1", q[1*W +: W], forced[1]);
        end
        cmd(2'b10, 1, 0, 0);
        tests++;
        if (q[1*W +: W] !== 4'h1 || forced[1] !== 0) begin
            fails++;
            $display("FAIL release_holds q=%h forced=%b need 1/0", q[1*W +: W], forced[1]);
        end
        wr(1, 4'h9);
        tests++;
        if (q[1*W +: W] !== 4'h9) begin fails++; $display("FAIL write_after_release got %h need 9", q[1*W +: W]); end
    endtask

    task automatic test_timed(input logic [H-1:0] hd, input int need);
        int cnt, pulses;
        cnt = 0; pulses = 0;
        cmd_valid = 1; cmd_op = 2'b11; cmd_ch = 2; cmd_data = 4'hA; cmd_hold = hd;
        tick();
        cmd_valid = 0;
        for (int i = 0; i < 12; i++) begin
            if (forced[2] && q[2*W +: W] === 4'hA) cnt++;
            if (expired[2]) pulses++;
            tests++;
            if (q !== eq || forced !== ef || expired !== ee) begin
                fails++;
                $display("FAIL timed_step%0d q=%h forced=%b expired=%b need %h/%b/%b", i, q, forced, expired, eq, ef, ee);
            end
            tick();
        end
        tests++;
        if (cnt !== need || pulses !== 1 || q[2*W +: W] !== 4'hA || forced[2] !== 0) begin
            fails++;
            $display("FAIL timed_hold%0d cycles=%0d pulses=%0d q=%h forced=%b need %0d/1/a/0", hd, cnt, pulses, q[2*W +: W], forced[2], need);
        end
    endtask

    task automatic test_same_edge;
        cmd(2'b01, 0, 4'h2, 0);
        cmd_valid = 1; cmd_op = 2'b10; cmd_ch = 0; wr_en = 1; wr_ch = 0; wr_data = 4'h5;
        tick();
        cmd_valid = 0; wr_en = 0;
        tick();
        tests++;
        if (q[0 +: W] !== 4'h5 || forced[0] !== 0) begin
            fails++;
            $display("FAIL release_with_write q=%h forced=%b need 5/0", q[0 +: W], forced[0]);
        end
        cmd_valid = 1; cmd_op = 2'b01; cmd_ch = 0; cmd_data = 4'hC; wr_en = 1; wr_ch = 0; wr_data = 4'h6;
        tick();
        cmd_valid = 0; wr_en = 0;
        tests++;
        if (q[0 +: W] !== 4'hC || forced[0] !== 1) begin
            fails++;
            $display("FAIL force_with_write q=%h forced=%b need c/1", q[0 +: W], forced[0]);
        end
        tick();
        cmd(2'b10, 0, 0, 0);
        tests++;
        if (q[0 +: W] !== 4'hC) begin fails++; $display("FAIL discarded_write_stays_lost got %h need c", q[0 +: W]); end
        cmd_valid = 1; cmd_op = 2'b01; cmd_ch = 3; cmd_data = 4'hE; wr_en = 1; wr_ch = 1; wr_data = 4'hB;
        tick();
        cmd_valid = 0; wr_en = 0;
        tests++;
        if (q[3*W +: W] !== 4'hE || forced[3] !== 1 || q[1*W +: W] !== 4'hB) begin
            fails++;
            $display("FAIL different_channels ch3=%h f3=%b ch1=%h need e/1/b", q[3*W +: W], forced[3], q[1*W +: W]);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int acc_n;
        acc_n = 0;
        cmd_valid = 1; cmd_op = 2'b00; cmd_ch = 0;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (cmd_ready !== ((i % 2) == 0)) begin
                fails++;
                $display("FAIL ready_alternate%0d got %b need %b", i, cmd_ready, (i % 2) == 0);
            end
            if (cmd_ready) acc_n++;
            tick();
        end
        cmd_valid = 0;
        tests++;
        if (acc_n !== 4) begin fails++; $display("FAIL accept_count got %0d need 4", acc_n); end
        tick();
        cmd_valid = 1; cmd_op = 2'b01; cmd_ch = 15; cmd_data = 4'hF;
        tick();
        cmd_valid = 0;
        tests++;
        if (cmd_err !== 1 || q !== eq || forced !== ef) begin
            fails++;
            $display("FAIL bad_channel err=%b q=%h forced=%b need 1/%h/%b", cmd_err, q, forced, eq, ef);
        end
        tick();
        tests++;
        if (cmd_err !== 0) begin fails++; $display("FAIL err_pulse_width got %b need 0", cmd_err); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            wr_en = ($urandom % 3) == 0;
            wr_ch = 2'($urandom);
            wr_data = W'($urandom);
            cmd_valid = ($urandom % 2) == 0;
            cmd_op = 2'($urandom);
            cmd_ch = ($urandom % 8 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            cmd_data = W'($urandom);
            cmd_hold = H'($urandom_range(0, 5));
            tick();
            tests++;
            if (q !== eq || forced !== ef || expired !== ee || cmd_err !== m_err || cmd_ready !== m_rdy) begin
                fails++;
                $display("FAIL random%0d q=%h f=%b x=%b e=%b r=%b need %h/%b/%b/%b/%b",
                         i, q, forced, expired, cmd_err, cmd_ready, eq, ef, ee, m_err, m_rdy);
            end
        end
        wr_en = 0; cmd_valid = 0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid;
        int pulses;
        pulses = 0;
        cmd_valid = 1; cmd_op = 2'b11; cmd_ch = 1; cmd_data = 4'h6; cmd_hold = 10;
        tick();
        cmd_valid = 0;
        tick(); tick();
        tests++;
        if (forced[1] !== 1) begin fails++; $display("FAIL timed10_active got %b need 1", forced[1]); end
        rst_n = 0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (q !== '0 || forced !== '0 || expired !== '0 || cmd_err !== 0 || cmd_ready !== 0) begin
                fails++;
                $display("FAIL reset_mid%0d q=%h f=%b x=%b e=%b r=%b need 0", i, q, forced, expired, cmd_err, cmd_ready);
            end
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1;
        tick();
        tests++;
        if (cmd_ready !== 1) begin fails++; $display("FAIL ready_after_mid_reset got %b need 1", cmd_ready); end
        for (int i = 0; i < 14; i++) begin
            if (expired !== '0 || forced !== '0) pulses++;
            tick();
        end
        tests++;
        if (pulses !== 0) begin fails++; $display("FAIL no_expiry_after_reset got %0d need 0", pulses); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_force_release();
        test_timed(3, 3);
        test_timed(0, 1);
        test_same_edge();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
